vga_sync_gen: RTL and testbench

Frame-timing source for the video pipeline. It produces the global frame counter (x, y) that every stream core (pattern generators, sprite and OSD cores) consumes. It also produces the pixel-rate tick and the monitor sync signals. The sync outputs are delayed to match the latency of the stream-core chain, so hsync and vsync line up with the final so_rgb at the VGA pins.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/sync_delay.sv | 42 ++++
 rtl/vga_sync_gen.sv | 90 +++++++++
 tb/tb_vga_sync_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and the shared count width
// used by the frame-timing source and anything that consumes x/y.
package vga_timing_pkg;

    localparam int CNT_W  = 11;

    localparam int DEF_HD = 640;
    localparam int DEF_HF = 16;
    localparam int DEF_HB = 48;
    localparam int DEF_HR = 96;
    localparam int DEF_VD = 480;
    localparam int DEF_VF = 10;
    localparam int DEF_VB = 33;
    localparam int DEF_VR = 2;

    localparam int DEF_HT = DEF_HD + DEF_HF + DEF_HB + DEF_HR;
    localparam int DEF_VT = DEF_VD + DEF_VF + DEF_VB + DEF_VR;

endpackage

// File: rtl/sync_delay.sv
// N-stage, W-bit shift register with an async active-low reset that
// preloads every stage with rst_val; N=0 is a straight wire.
module sync_delay #(
    parameter int N = 2,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (N == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, rst_val};
            assign dout = din;
        end else begin : g_dly
            logic [N-1:0][W-1:0] stage_q, stage_d;

            always_comb begin
                stage_d    = stage_q;
                stage_d[0] = din;
                for (int i = 1; i < N; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= {N{rst_val}};
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Frame-timing source: pixel-rate tick, global (x, y) counters, and
// hsync/vsync/video_on delayed to line up with the stream-core chain.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CD       = 4,
    parameter int HD       = DEF_HD,
    parameter int HF       = DEF_HF,
    parameter int HB       = DEF_HB,
    parameter int HR       = DEF_HR,
    parameter int VD       = DEF_VD,
    parameter int VF       = DEF_VF,
    parameter int VB       = DEF_VB,
    parameter int VR       = DEF_VR,
    parameter int SYNC_DLY = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             p_tick,
    output logic             frame_start,
    output logic             video_on_raw,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on
);

    localparam int HT    = HD + HF + HB + HR;
    localparam int VT    = VD + VF + VB + VR;
    localparam int DIV_W = $clog2(CD);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hs_raw_q, hs_raw_d;
    logic             vs_raw_q, vs_raw_d;

    assign p_tick       = (div_cnt_q == DIV_W'(CD - 1));
    assign x            = h_cnt_q;
    assign y            = v_cnt_q;
    assign video_on_raw = (h_cnt_q < CNT_W'(HD)) && (v_cnt_q < CNT_W'(VD));
    assign frame_start  = p_tick && (h_cnt_q == '0) && (v_cnt_q == '0);

    always_comb begin
        div_cnt_d = p_tick ? '0 : div_cnt_q + DIV_W'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (p_tick) begin
            if (h_cnt_q == CNT_W'(HT - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == CNT_W'(VT - 1)) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
        // Sync windows are decoded from the current counts, so the raw
        // sync flops trail x/y by one clock.
        hs_raw_d = !((h_cnt_q >= CNT_W'(HD + HF)) && (h_cnt_q < CNT_W'(HD + HF + HR)));
        vs_raw_d = !((v_cnt_q >= CNT_W'(VD + VF)) && (v_cnt_q < CNT_W'(VD + VF + VR)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            hs_raw_q  <= 1'b1;
            vs_raw_q  <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hs_raw_q  <= hs_raw_d;
            vs_raw_q  <= vs_raw_d;
        end
    end

    sync_delay #(
        .N (SYNC_DLY),
        .W (3)
    ) u_sync_delay (
        .clk     (clk),
        .rst_n   (reset),
        .rst_val (3'b110),
        .din     ({hs_raw_q, vs_raw_q, video_on_raw}),
        .dout    ({hsync, vsync, video_on})
    );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a shrunken timing so whole
// frames fit in a short run; expected values come from clock-count arithmetic.
module tb_vga_sync_gen;
    localparam int CD = 4;
    localparam int HD = 8, HF = 2, HB = 3, HR = 4;
    localparam int VD = 5, VF = 1, VB = 2, VR = 2;
    localparam int DLY = 2;
    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;
    localparam int FRAME = HT * VT * CD;

    logic clk, reset;
    logic [10:0] x, y;
    logic p_tick, frame_start, video_on_raw, hsync, vsync, video_on;
    logic [27:0] obs;
    localparam logic [27:0] RST_VAL = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    int n;
    int n_cmp = 0;
    int n_err = 0;

    vga_sync_gen #(
        .CD(CD), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR), .SYNC_DLY(DLY)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .p_tick(p_tick),
        .frame_start(frame_start), .video_on_raw(video_on_raw),
        .hsync(hsync), .vsync(vsync), .video_on(video_on)
    );

    assign obs = {x, y, p_tick, frame_start, video_on_raw, hsync, vsync, video_on};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    function automatic int hc(input int m);
        return (m / CD) % HT;
    endfunction

    function automatic int vc(input int m);
        return (m / (CD * HT)) % VT;
    endfunction

    function automatic logic [27:0] exp_out(input int k);
        int m;
        logic pt, fs, vor, hs, vs, von;
        pt  = (k % CD) == CD - 1;
        fs  = pt && hc(k) == 0 && vc(k) == 0;
        vor = hc(k) < HD && vc(k) < VD;
        m   = k - 1 - DLY;
        hs  = (m < 0) ? 1'b1 : !(hc(m) >= HD + HF && hc(m) < HD + HF + HR);
        vs  = (m < 0) ? 1'b1 : !(vc(m) >= VD + VF && vc(m) < VD + VF + VR);
        m   = k - DLY;
        von = (m < 0) ? 1'b0 : (hc(m) < HD && vc(m) < VD);
        return {11'(hc(k)), 11'(vc(k)), pt, fs, vor, hs, vs, von};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (obs !== RST_VAL) begin
                n_err++;
                $display("FAIL reset_state: got %h want %h", obs, RST_VAL);
            end
        end
    endtask

    task automatic test_reset_release();
        @(negedge clk); reset = 1'b1; #1;
        for (int k = 0; k < 3 * CD + 2; k++) begin
            n_cmp++;
            if (p_tick !== ((k + 1) % CD == 0) || frame_start !== (k == CD - 1)) begin
                n_err++;
                $display("FAIL release_tick k=%0d: got pt=%b fs=%b", k, p_tick, frame_start);
            end
            if (k == CD) begin
                n_cmp++;
                if (x !== 11'd1) begin
                    n_err++;
                    $display("FAIL release_x: got %0d want 1", x);
                end
            end
            n_cmp++;
            if (obs !== exp_out(n)) begin
                n_err++;
                $display("FAIL release_model n=%0d: got %h want %h", n, obs, exp_out(n));
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_full_frame();
        int hs_low = 0, vs_low = 0, fs_cnt = 0, bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk); #1;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frame_start) fs_cnt++;
            n_cmp++;
            if (obs !== exp_out(n)) begin
                n_err++;
                if (bad++ < 5) $display("FAIL frame_model n=%0d: got %h want %h", n, obs, exp_out(n));
            end
        end
        n_cmp++;
        if (hs_low != VT * HR * CD || vs_low != VR * HT * CD || fs_cnt != 1) begin
            n_err++;
            $display("FAIL frame_counts: got hs=%0d vs=%0d fs=%0d want hs=%0d vs=%0d fs=1",
                     hs_low, vs_low, fs_cnt, VT * HR * CD, VR * HT * CD);
        end
    endtask

    task automatic test_delay_align();
        logic [10:0] px = x;
        int c = 0;
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk); #1;
            if (x == 11'(HD + HF) && px != 11'(HD + HF)) found = 1;
            px = x;
        end
        if (found) begin
            while (hsync !== 1'b0 && c < 20) begin
                @(negedge clk); #1;
                c++;
            end
        end
        n_cmp++;
        if (!found || c != DLY + 1) begin
            n_err++;
            $display("FAIL delay_align: found=%0d got %0d clocks want %0d", found, c, DLY + 1);
        end
    endtask

    task automatic test_wrap();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk); #1;
            if (x == 11'(HT - 1) && y == 11'(VT - 1) && p_tick) found = 1;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (!found || x !== 11'd0 || y !== 11'd0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_xy: found=%0d got x=%0d y=%0d fs=%b want 0 0 0", found, x, y, frame_start);
        end
        repeat (CD - 1) @(negedge clk);
        #1;
        n_cmp++;
        if (frame_start !== 1'b1 || p_tick !== 1'b1 || x !== 11'd0 || y !== 11'd0) begin
            n_err++;
            $display("FAIL wrap_fs: got fs=%b pt=%b x=%0d y=%0d want 1 1 0 0", frame_start, p_tick, x, y);
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk); #1;
            if (x == 11'(HD + HF + 1) && y == 11'd3) found = 1;
        end
        n_cmp++;
        if (!found || hsync !== 1'b0 || obs !== exp_out(n)) begin
            n_err++;
            $display("FAIL async_pre: found=%0d got %h want %h", found, obs, exp_out(n));
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== RST_VAL) begin
            n_err++;
            $display("FAIL async_immediate: got %h want %h", obs, RST_VAL);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (obs !== RST_VAL) begin
                n_err++;
                $display("FAIL async_hold: got %h want %h", obs, RST_VAL);
            end
        end
        @(negedge clk); reset = 1'b1; #1;
        for (int k = 0; k < 4 * CD; k++) begin
            n_cmp++;
            if (obs !== exp_out(k) || n != k) begin
                n_err++;
                $display("FAIL async_restart k=%0d: got %h want %h", k, obs, exp_out(k));
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_random_resets();
        for (int it = 0; it < 8; it++) begin
            int len = $urandom_range(20, 900);
            int off = $urandom_range(1, 8);
            int hold = $urandom_range(1, 5);
            int bad = 0;
            for (int i = 0; i < len; i++) begin
                @(negedge clk); #1;
                n_cmp++;
                if (obs !== exp_out(n)) begin
                    n_err++;
                    if (bad++ < 3) $display("FAIL random_model it=%0d n=%0d: got %h want %h", it, n, obs, exp_out(n));
                end
            end
            if (off >= 4) off++;
            #(off) reset = 1'b0;
            #1;
            n_cmp++;
            if (obs !== RST_VAL) begin
                n_err++;
                $display("FAIL random_reset it=%0d: got %h want %h", it, obs, RST_VAL);
            end
            repeat (hold) @(negedge clk);
            reset = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_reset_release();
        test_full_frame();
        test_delay_align();
        test_wrap();
        test_async_reset();
        test_random_resets();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
